// File: rtl/decode_issue_queue_if.sv
// Fetch/issue bundle between the fetch stage, the decode issue queue and the
// execute-stage load tracker. The queue connects through the slave modport.
interface decode_issue_queue_if #(
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int REG_BITS = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshake: an instruction moves from fetch into the queue on a clock edge
  // where fetch_valid and fetch_ready are both high and flush is low.
  // fetch_ready comes from registered state only. The fetch side holds
  // fetch_instr stable while fetch_valid is high and ready is low.
  logic                fetch_valid;
  logic [INSTR_W-1:0]  fetch_instr;
  logic                fetch_ready;
  logic                flush;
  logic                mem_stall;
  logic                ld_valid_e;
  logic [REG_BITS-1:0] ld_dest_e;
  logic [INSTR_W-1:0]  issue_instr;
  logic                issue_valid;
  logic                data_hazard;
  logic [CNT_W-1:0]    count;

  modport master (
    output fetch_valid, fetch_instr, flush, mem_stall, ld_valid_e, ld_dest_e,
    input  fetch_ready, issue_instr, issue_valid, data_hazard, count
  );

  modport slave (
    input  fetch_valid, fetch_instr, flush, mem_stall, ld_valid_e, ld_dest_e,
    output fetch_ready, issue_instr, issue_valid, data_hazard, count
  );
endinterface

// File: rtl/decode_issue_queue.sv
// Instruction queue and registered issue slot with load-use bubble injection,
// branch flush and memory-stall freeze. Define DIQ_BYPASS_EN to let an
// instruction skip an empty queue straight into the issue slot.
module decode_issue_queue #(
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter int                 REG_BITS  = 3,
  parameter int                 RS_LSB    = 8,
  parameter int                 RT_LSB    = 5,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input logic               clk,
  input logic               rst,
  decode_issue_queue_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [INSTR_W-1:0] issue_q;
  logic               issue_valid_q;

  logic [INSTR_W-1:0] head;
  logic               empty, full;
  logic               fetch_ready;
  logic               data_hazard;
  logic               bypass;
  logic               push, pop;

  function automatic logic hits_load(input logic [INSTR_W-1:0] instr,
                                     input logic ld_valid,
                                     input logic [REG_BITS-1:0] ld_dest);
    return ld_valid && ((instr[RS_LSB +: REG_BITS] == ld_dest) ||
                        (instr[RT_LSB +: REG_BITS] == ld_dest));
  endfunction

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready follows the registered count only, so a pop in the same cycle never
  // frees a slot for a push while full.
  assign fetch_ready = (count_q != CNT_W'(DEPTH));

`ifdef DIQ_BYPASS_EN
  logic fetch_hazard;
  assign fetch_hazard = bus.fetch_valid &&
                        hits_load(bus.fetch_instr, bus.ld_valid_e, bus.ld_dest_e);
  // With an empty queue the incoming instruction stands in for the head.
  assign data_hazard  = empty ? fetch_hazard
                              : hits_load(head, bus.ld_valid_e, bus.ld_dest_e);
  assign bypass       = empty && bus.fetch_valid && !bus.flush &&
                        !bus.mem_stall && !fetch_hazard;
`else
  assign data_hazard  = !empty && hits_load(head, bus.ld_valid_e, bus.ld_dest_e);
  assign bypass       = 1'b0;
`endif

  assign push = bus.fetch_valid && fetch_ready && !bus.flush && !bypass;
  assign pop  = !bus.flush && !bus.mem_stall && !data_hazard && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      issue_q       <= NOP_INSTR;
      issue_valid_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      issue_q       <= NOP_INSTR;
      issue_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.fetch_instr;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // Stall freezes the slot; a hazard or an empty queue inserts a bubble.
      if (bus.mem_stall) begin
        issue_q       <= issue_q;
        issue_valid_q <= issue_valid_q;
      end else if (data_hazard) begin
        issue_q       <= NOP_INSTR;
        issue_valid_q <= 1'b0;
      end else if (pop) begin
        issue_q       <= head;
        issue_valid_q <= 1'b1;
      end else if (bypass) begin
        issue_q       <= bus.fetch_instr;
        issue_valid_q <= 1'b1;
      end else begin
        issue_q       <= NOP_INSTR;
        issue_valid_q <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.issue_instr = issue_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.data_hazard = data_hazard;
  assign bus.count       = count_q;

  logic unused_full;
  assign unused_full = full;
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: reset, back-to-back issue, stall fill,
// load-use bubbles, flush, pointer wrap and the (optional) bypass path.
module tb_decode_issue_queue;
  localparam int               INSTR_W = 16;
  localparam int               DEPTH   = 4;
  localparam int               REG_BITS = 3;
  localparam logic [15:0]      NOP     = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [INSTR_W-1:0] exp_q[$];

  decode_issue_queue_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .REG_BITS(REG_BITS)) bus ();

  decode_issue_queue #(
    .INSTR_W(INSTR_W), .DEPTH(DEPTH), .REG_BITS(REG_BITS),
    .RS_LSB(8), .RT_LSB(5), .NOP_INSTR(16'h0800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = '0;
    bus.flush       = 1'b0;
    bus.mem_stall   = 1'b0;
    bus.ld_valid_e  = 1'b0;
    bus.ld_dest_e   = '0;
  endtask

  task automatic push_one(input logic [15:0] instr);
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = instr;
    step();
    bus.fetch_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.issue_instr !== NOP) begin errors++; $display("FAIL reset_issue_instr: got %h expected %h", bus.issue_instr, NOP); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", bus.issue_valid); end
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b expected 1", bus.fetch_ready); end
    checks++; if (bus.data_hazard !== 1'b0) begin errors++; $display("FAIL reset_data_hazard: got %b expected 0", bus.data_hazard); end
  endtask

  task automatic test_back_to_back();
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = 16'h4101;
    step();
    bus.fetch_instr = 16'h4202;
`ifdef DIQ_BYPASS_EN
    checks++; if (bus.issue_instr !== 16'h4101 || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b expected 4101/1", bus.issue_instr, bus.issue_valid); end
    step();
    bus.fetch_valid = 1'b0;
`else
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency: got valid %b expected 0", bus.issue_valid); end
    step();
    bus.fetch_valid = 1'b0;
    checks++; if (bus.issue_instr !== 16'h4101 || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b expected 4101/1", bus.issue_instr, bus.issue_valid); end
    step();
`endif
    checks++; if (bus.issue_instr !== 16'h4202 || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b expected 4202/1", bus.issue_instr, bus.issue_valid); end
    step();
    checks++; if (bus.issue_instr !== NOP || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %h/%b expected 0800/0", bus.issue_instr, bus.issue_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_mem_stall();
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(16'h1111 * 16'(i + 1));
    end
    for (int i = 0; i < 5; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_instr = exp_q[i];
      step();
    end
    bus.fetch_valid = 1'b0;
    exp_q.pop_back();  // fifth instruction was offered while full
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", bus.count); end
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", bus.fetch_ready); end
    checks++; if (bus.issue_valid !== 1'b0 || bus.issue_instr !== NOP) begin errors++; $display("FAIL stall_hold: got %h/%b expected 0800/0", bus.issue_instr, bus.issue_valid); end
    bus.mem_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.issue_instr !== exp_q[0] || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL stall_drain_%0d: got %h/%b expected %h/1", i, bus.issue_instr, bus.issue_valid, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    step();
    checks++; if (bus.issue_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL stall_empty: got valid %b count %0d expected 0/0", bus.issue_valid, bus.count); end
  endtask

  task automatic test_full_pop();
    exp_q.delete();
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'hB001 + 16'(i));
      push_one(16'hB001 + 16'(i));
    end
    exp_q.push_back(16'hB005);
    bus.mem_stall   = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = 16'hB005;
    #1;
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.fetch_ready); end
    step();
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_no_push: got count %0d expected 3", bus.count); end
    checks++; if (bus.issue_instr !== exp_q[0]) begin errors++; $display("FAIL full_pop_issue: got %h expected %h", bus.issue_instr, exp_q[0]); end
    void'(exp_q.pop_front());
    step();
    bus.fetch_valid = 1'b0;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got count %0d expected 3", bus.count); end
    while (exp_q.size() > 0) begin
      checks++; if (bus.issue_instr !== exp_q[0] || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL full_drain: got %h/%b expected %h/1", bus.issue_instr, bus.issue_valid, exp_q[0]); end
      void'(exp_q.pop_front());
      step();
    end
    checks++; if (bus.count !== 3'd0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL full_end: got count %0d valid %b expected 0/0", bus.count, bus.issue_valid); end
  endtask

  task automatic test_data_hazard();
    // Rs field match
    bus.ld_valid_e = 1'b1;
    bus.ld_dest_e  = 3'd1;
    push_one(16'h8120);
    #1;
    checks++; if (bus.data_hazard !== 1'b1) begin errors++; $display("FAIL hazard_rs: got %b expected 1", bus.data_hazard); end
    step();
    checks++; if (bus.issue_valid !== 1'b0 || bus.issue_instr !== NOP) begin errors++; $display("FAIL hazard_bubble: got %h/%b expected 0800/0", bus.issue_instr, bus.issue_valid); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL hazard_count: got %0d expected 1", bus.count); end
    bus.ld_valid_e = 1'b0;
    #1;
    checks++; if (bus.data_hazard !== 1'b0) begin errors++; $display("FAIL hazard_clear: got %b expected 0", bus.data_hazard); end
    step();
    checks++; if (bus.issue_instr !== 16'h8120 || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL hazard_release: got %h/%b expected 8120/1", bus.issue_instr, bus.issue_valid); end
    // Rt field match, then a load to an unrelated register
    bus.ld_valid_e = 1'b1;
    bus.ld_dest_e  = 3'd2;
    push_one(16'h0040);
    #1;
    checks++; if (bus.data_hazard !== 1'b1) begin errors++; $display("FAIL hazard_rt: got %b expected 1", bus.data_hazard); end
    bus.ld_dest_e = 3'd3;
    #1;
    checks++; if (bus.data_hazard !== 1'b0) begin errors++; $display("FAIL hazard_nomatch: got %b expected 0", bus.data_hazard); end
    step();
    checks++; if (bus.issue_instr !== 16'h0040 || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL hazard_nomatch_issue: got %h/%b expected 0040/1", bus.issue_instr, bus.issue_valid); end
    bus.ld_valid_e = 1'b0;
    step();
  endtask

  task automatic test_flush();
    bus.mem_stall = 1'b1;
    push_one(16'h1001);
    push_one(16'h1002);
    push_one(16'h1003);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", bus.count); end
    bus.mem_stall   = 1'b0;
    bus.flush       = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = 16'h1004;
    step();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
    checks++; if (bus.issue_valid !== 1'b0 || bus.issue_instr !== NOP) begin errors++; $display("FAIL flush_issue: got %h/%b expected 0800/0", bus.issue_instr, bus.issue_valid); end
    step();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %h/%b expected 0800/0", bus.issue_instr, bus.issue_valid); end
    push_one(16'h1005);
`ifndef DIQ_BYPASS_EN
    step();
`endif
    checks++; if (bus.issue_instr !== 16'h1005 || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL flush_resume: got %h/%b expected 1005/1", bus.issue_instr, bus.issue_valid); end
    step();
  endtask

  task automatic test_wrap();
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      bus.mem_stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        exp_q.push_back(16'hA000 + 16'(r * 16 + i));
        push_one(16'hA000 + 16'(r * 16 + i));
      end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL wrap_fill_%0d: got count %0d expected 4", r, bus.count); end
      bus.mem_stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        step();
        checks++; if (bus.issue_instr !== exp_q[0] || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL wrap_drain_%0d_%0d: got %h/%b expected %h/1", r, i, bus.issue_instr, bus.issue_valid, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    step();
    checks++; if (bus.count !== 3'd0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wrap_end: got count %0d valid %b expected 0/0", bus.count, bus.issue_valid); end
  endtask

  task automatic test_reset_mid();
    bus.mem_stall = 1'b1;
    push_one(16'h2001);
    push_one(16'h2002);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL rstmid_pre: got count %0d expected 2", bus.count); end
    rst             = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = 16'h2003;
    step();
    rst = 1'b0;
    idle_inputs();
    checks++; if (bus.count !== 3'd0 || bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL rstmid_count: got count %0d ready %b expected 0/1", bus.count, bus.fetch_ready); end
    step();
    checks++; if (bus.issue_valid !== 1'b0 || bus.issue_instr !== NOP) begin errors++; $display("FAIL rstmid_issue: got %h/%b expected 0800/0", bus.issue_instr, bus.issue_valid); end
  endtask

  task automatic test_bypass_path();
    push_one(16'hC0FF);
`ifdef DIQ_BYPASS_EN
    checks++; if (bus.issue_instr !== 16'hC0FF || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL bypass_issue: got %h/%b expected c0ff/1", bus.issue_instr, bus.issue_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", bus.count); end
`else
    checks++; if (bus.issue_valid !== 1'b0 || bus.count !== 3'd1) begin errors++; $display("FAIL queued_first_edge: got valid %b count %0d expected 0/1", bus.issue_valid, bus.count); end
    step();
    checks++; if (bus.issue_instr !== 16'hC0FF || bus.issue_valid !== 1'b1) begin errors++; $display("FAIL queued_issue: got %h/%b expected c0ff/1", bus.issue_instr, bus.issue_valid); end
`endif
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_mem_stall();
    test_full_pop();
    test_data_hazard();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_bypass_path();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
